// File: rtl/eeprom_bus_sequencer.sv
// Owner of the shared cartridge EEPROM bus: arbitrates CoCo cartridge cycles against Arduino
// requests and times the een/wee strobes. Optional macro BANK0_WP_EN write-protects bank 0.
//
// state   | meaning
// IDLE    | bus parked, waiting for CoCo select or Arduino request
// COCO    | CoCo owns the bus, een low on the latched CoCo bank
// ASETUP  | Arduino granted, address/bank settling before strobe
// APULSE  | Arduino strobe low (een for read, wee for write)
// AHOLD   | strobes released, Arduino still owns the bus
// RECOVER | EEPROM write recovery, Arduino requests stall
// ABORT   | Arduino read aborted by CoCo, strobes off before CoCo takes the bus
module eeprom_bus_sequencer #(
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c_power,
  input  logic       cts_n,
  input  logic [1:0] coco_bank,
  input  logic       ard_req,
  input  logic       ard_rw,
  input  logic [1:0] ard_bank,
  output logic       ard_gnt,
  output logic       ard_done,
  output logic       ard_err,
  output logic       c_busen,
  output logic       ard_busmaster,
  output logic       een,
  output logic       wee,
  output logic [1:0] bank,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COCO    = 3'd1,
    ASETUP  = 3'd2,
    APULSE  = 3'd3,
    AHOLD   = 3'd4,
    RECOVER = 3'd5,
    ABORT   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rec_cnt;
  logic             rec_pend;
  logic             is_read;
  logic             cts_q1, cts_q2;
  logic             pwr_q1, pwr_q2;
  logic             cs;
  logic             wp_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      cts_q1 <= 1'b1;
      cts_q2 <= 1'b1;
      pwr_q1 <= 1'b0;
      pwr_q2 <= 1'b0;
    end else begin
      cts_q1 <= cts_n;
      cts_q2 <= cts_q1;
      pwr_q1 <= c_power;
      pwr_q2 <= pwr_q1;
    end
  end

  assign cs = ~cts_q2 & pwr_q2;

`ifdef BANK0_WP_EN
  assign wp_hit = (ard_bank == 2'b00);
`else
  assign wp_hit = 1'b0;
`endif

  assign ard_busmaster = ~ard_gnt;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rec_cnt  <= '0;
      rec_pend <= 1'b0;
      is_read  <= 1'b0;
      ard_gnt  <= 1'b0;
      ard_done <= 1'b0;
      ard_err  <= 1'b0;
      c_busen  <= 1'b0;
      een      <= 1'b1;
      wee      <= 1'b1;
      bank     <= 2'b00;
    end else begin
      ard_done <= 1'b0;
      ard_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          c_busen <= ~pwr_q2;
          if (cs) begin
            state   <= COCO;
            bank    <= coco_bank;
            c_busen <= 1'b0;
            een     <= 1'b0;
          end else if (ard_req && !ard_rw && (pwr_q2 || wp_hit)) begin
            ard_err <= 1'b1;
          end else if (ard_req) begin
            state   <= ASETUP;
            ard_gnt <= 1'b1;
            c_busen <= 1'b1;
            bank    <= ard_bank;
            is_read <= ard_rw;
            cnt     <= SETUP_LD;
          end
        end
        COCO: begin
          if (!cs) begin
            een     <= 1'b1;
            c_busen <= ~pwr_q2;
            // A write recovery interrupted by the CoCo picks up where it left off
            if (rec_pend) begin
              state    <= RECOVER;
              cnt      <= rec_cnt;
              rec_pend <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        ASETUP: begin
          if (cs) begin
            state   <= ABORT;
            ard_gnt <= 1'b0;
            ard_err <= 1'b1;
            c_busen <= 1'b0;
            bank    <= coco_bank;
          end else if (cnt == '0) begin
            state <= APULSE;
            cnt   <= PULSE_LD;
            if (is_read) een <= 1'b0;
            else         wee <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        APULSE: begin
          if (cs && is_read) begin
            state   <= ABORT;
            ard_gnt <= 1'b0;
            ard_err <= 1'b1;
            een     <= 1'b1;
            wee     <= 1'b1;
            c_busen <= 1'b0;
            bank    <= coco_bank;
          end else if (cnt == '0) begin
            state <= AHOLD;
            een   <= 1'b1;
            wee   <= 1'b1;
            cnt   <= HOLD_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        AHOLD: begin
          if (cnt == '0) begin
            ard_done <= 1'b1;
            ard_gnt  <= 1'b0;
            c_busen  <= ~pwr_q2;
            if (is_read) begin
              state <= IDLE;
            end else begin
              state <= RECOVER;
              cnt   <= RECOVER_LD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOVER: begin
          c_busen <= ~pwr_q2;
          if (cs) begin
            state    <= COCO;
            bank     <= coco_bank;
            c_busen  <= 1'b0;
            een      <= 1'b0;
            rec_cnt  <= cnt;
            rec_pend <= 1'b1;
          end else if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ABORT: begin
          // Bank and ownership settled last clock; only now may een fall
          if (cs) begin
            state <= COCO;
            een   <= 1'b0;
          end else begin
            state   <= IDLE;
            c_busen <= ~pwr_q2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_bus_sequencer.sv
// Directed bench for eeprom_bus_sequencer: Arduino write/read timing, CoCo cycles,
// aborts, refusals and synchronous reset. Follows BANK0_WP_EN when defined.
module tb_eeprom_bus_sequencer;

  logic       clk;
  logic       reset;
  logic       c_power;
  logic       cts_n;
  logic [1:0] coco_bank;
  logic       ard_req;
  logic       ard_rw;
  logic [1:0] ard_bank;
  logic       ard_gnt;
  logic       ard_done;
  logic       ard_err;
  logic       c_busen;
  logic       ard_busmaster;
  logic       een;
  logic       wee;
  logic [1:0] bank;
  logic       busy;

  int checks;
  int errors;
  logic seen;

  eeprom_bus_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .c_power       (c_power),
    .cts_n         (cts_n),
    .coco_bank     (coco_bank),
    .ard_req       (ard_req),
    .ard_rw        (ard_rw),
    .ard_bank      (ard_bank),
    .ard_gnt       (ard_gnt),
    .ard_done      (ard_done),
    .ard_err       (ard_err),
    .c_busen       (c_busen),
    .ard_busmaster (ard_busmaster),
    .een           (een),
    .wee           (wee),
    .bank          (bank),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"},  32'(ard_gnt), 0);
    check({tag, "_done"}, 32'(ard_done), 0);
    check({tag, "_err"},  32'(ard_err), 0);
    check({tag, "_cbus"}, 32'(c_busen), 0);
    check({tag, "_bm"},   32'(ard_busmaster), 1);
    check({tag, "_een"},  32'(een), 1);
    check({tag, "_wee"},  32'(wee), 1);
    check({tag, "_bank"}, 32'(bank), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    c_power   = 1'b0;
    cts_n     = 1'b1;
    coco_bank = 2'b00;
    ard_req   = 1'b0;
    ard_rw    = 1'b1;
    ard_bank  = 2'b00;
    repeat (3) tick();
    check_reset_vals("rst");

    // Arduino write with CoCo off, bank 2
    reset = 1'b0;
    repeat (2) tick();
    check("idle_parked", 32'(c_busen), 1);
    ard_rw = 1'b0; ard_bank = 2'd2; ard_req = 1'b1;
    tick();
    check("wr_gnt",  32'(ard_gnt), 1);
    check("wr_bm",   32'(ard_busmaster), 0);
    check("wr_bank", 32'(bank), 2);
    check("wr_busy", 32'(busy), 1);
    check("wr_cbus", 32'(c_busen), 1);
    tick();
    check("wr_setup_wee", 32'(wee), 1);
    tick();
    check("wr_pulse0", 32'(wee), 0);
    check("wr_pulse_een", 32'(een), 1);
    ard_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr_pulse", 32'(wee), 0);
    end
    tick();
    check("wr_release", 32'(wee), 1);
    tick();
    check("wr_hold_done", 32'(ard_done), 0);
    check("wr_hold_gnt", 32'(ard_gnt), 1);
    tick();
    check("wr_done", 32'(ard_done), 1);
    check("wr_done_gnt", 32'(ard_gnt), 0);

    // Recovery: a new request stalls for 16 clocks, then is granted
    ard_req = 1'b1;
    tick();
    check("wr_done_pulse", 32'(ard_done), 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ard_gnt || ard_err) seen = 1'b1;
    end
    check("rec_stall", 32'(seen), 0);
    tick();
    check("rec_regrant", 32'(ard_gnt), 1);

    // Synchronous reset in the middle of the write pulse
    tick();
    tick();
    check("wr2_pulse", 32'(wee), 0);
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    ard_req = 1'b0;

    // CoCo cartridge cycle
    c_power = 1'b1;
    repeat (3) tick();
    check("pwr_idle_cbus", 32'(c_busen), 0);
    check("pwr_idle_busy", 32'(busy), 0);
    coco_bank = 2'd3; cts_n = 1'b0;
    tick();
    tick();
    check("coco_sync_een", 32'(een), 1);
    tick();
    check("coco_een",  32'(een), 0);
    check("coco_cbus", 32'(c_busen), 0);
    check("coco_bank", 32'(bank), 3);
    check("coco_busy", 32'(busy), 1);
    check("coco_wee",  32'(wee), 1);
    coco_bank = 2'd1;
    tick();
    check("coco_bank_latched", 32'(bank), 3);
    cts_n = 1'b1;
    tick();
    tick();
    check("coco_still", 32'(een), 0);
    tick();
    check("coco_exit_een", 32'(een), 1);
    check("coco_exit_busy", 32'(busy), 0);

    // Write refused while CoCo powered
    ard_rw = 1'b0; ard_bank = 2'd1; ard_req = 1'b1;
    tick();
    check("pwr_wr_err", 32'(ard_err), 1);
    check("pwr_wr_gnt", 32'(ard_gnt), 0);
    check("pwr_wr_wee", 32'(wee), 1);
    ard_req = 1'b0;
    tick();
    check("pwr_wr_err_pulse", 32'(ard_err), 0);

    // Arduino read aborted in setup by CoCo select
    coco_bank = 2'd2;
    ard_rw = 1'b1; ard_bank = 2'd1; ard_req = 1'b1; cts_n = 1'b0;
    tick();
    check("rd_gnt", 32'(ard_gnt), 1);
    check("rd_bank", 32'(bank), 1);
    tick();
    check("rd_setup_een", 32'(een), 1);
    tick();
    check("abort_err", 32'(ard_err), 1);
    check("abort_gnt", 32'(ard_gnt), 0);
    check("abort_een", 32'(een), 1);
    check("abort_bank", 32'(bank), 2);
    ard_req = 1'b0;
    tick();
    check("abort_coco_een", 32'(een), 0);
    check("abort_err_pulse", 32'(ard_err), 0);
    cts_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ard_done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 0);
    check("abort_idle", 32'(busy), 0);

    // Bank-0 write with CoCo off
    c_power = 1'b0;
    repeat (3) tick();
    ard_rw = 1'b0; ard_bank = 2'd0; ard_req = 1'b1;
    tick();
`ifdef BANK0_WP_EN
    check("wp_err", 32'(ard_err), 1);
    check("wp_gnt", 32'(ard_gnt), 0);
    ard_req = 1'b0;
    tick();
    check("wp_wee", 32'(wee), 1);
    ard_bank = 2'd1; ard_req = 1'b1;
    tick();
    check("wp_b1_gnt", 32'(ard_gnt), 1);
`else
    check("b0_gnt", 32'(ard_gnt), 1);
    check("b0_err", 32'(ard_err), 0);
`endif
    tick();
    tick();
    check("b_pulse", 32'(wee), 0);
    reset = 1'b1;
    ard_req = 1'b0;
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
